// File: rtl/cmp_pkg.sv
//------------------------------------------------------------------------------
// Module  : cmp_pkg
// Brief   : Shared types and constants for seq_magnitude_comparator.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cmp_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;
    localparam int NCHUNK        = DEFAULT_WIDTH / DEFAULT_CHUNK;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result encoding: {gt, eq, lt}
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmp_chunk_slice.sv
//------------------------------------------------------------------------------
// Module  : cmp_chunk_slice
// Brief   : Combinational CHUNK-bit unsigned magnitude compare.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cmp_chunk_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

`default_nettype wire

// File: rtl/seq_magnitude_comparator.sv
//------------------------------------------------------------------------------
// Module  : seq_magnitude_comparator
// Brief   : Multi-cycle MSB-first chunked magnitude comparator with early exit.
//           Optional min/max outputs are enabled by defining CMP_MINMAX_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt_out,
    output logic             eq_out,
    output logic             lt_out
`ifdef CMP_MINMAX_EN
    ,
    output logic [WIDTH-1:0] min_out,
    output logic [WIDTH-1:0] max_out
`endif
);

    localparam int N_CHUNK = WIDTH / CHUNK;
    localparam int IDX_W   = idx_width(N_CHUNK);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2:0]         result;
    logic [CHUNK-1:0]   a_chunks [N_CHUNK];
    logic [CHUNK-1:0]   b_chunks [N_CHUNK];
    logic               s_gt;
    logic               s_eq;
    logic               s_lt;

`ifdef CMP_MINMAX_EN
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   b_raw;
`endif

    generate
        for (genvar g = 0; g < N_CHUNK; g++) begin : g_chunks
            assign a_chunks[g] = a_q[g*CHUNK +: CHUNK];
            assign b_chunks[g] = b_q[g*CHUNK +: CHUNK];
        end
    endgenerate

    cmp_chunk_slice #(.CHUNK(CHUNK)) u_slice (
        .a  (a_chunks[idx]),
        .b  (b_chunks[idx]),
        .gt (s_gt),
        .eq (s_eq),
        .lt (s_lt)
    );

    assign gt_out = result[2];
    assign eq_out = result[1];
    assign lt_out = result[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= RES_NONE;
            idx       <= IDX_W'(N_CHUNK - 1);
            a_q       <= '0;
            b_q       <= '0;
`ifdef CMP_MINMAX_EN
            a_raw     <= '0;
            b_raw     <= '0;
            min_out   <= '0;
            max_out   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        // Flipping the sign bit maps two's-complement order onto unsigned order
                        a_q      <= {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
                        b_q      <= {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
`ifdef CMP_MINMAX_EN
                        a_raw    <= a;
                        b_raw    <= b;
`endif
                        result   <= RES_NONE;
                        idx      <= IDX_W'(N_CHUNK - 1);
                        in_ready <= 1'b0;
                        state    <= CMP;
                    end
                end
                CMP: begin
                    if (!s_eq) begin
                        result    <= s_gt ? RES_GT : (s_lt ? RES_LT : RES_NONE);
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef CMP_MINMAX_EN
                        min_out   <= s_gt ? b_raw : a_raw;
                        max_out   <= s_gt ? a_raw : b_raw;
`endif
                    end else if (idx == '0) begin
                        result    <= RES_EQ;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef CMP_MINMAX_EN
                        min_out   <= a_raw;
                        max_out   <= a_raw;
`endif
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        result    <= RES_NONE;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    result    <= RES_NONE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_magnitude_comparator.sv
//------------------------------------------------------------------------------
// Module  : tb_seq_magnitude_comparator
// Brief   : Directed self-checking bench for seq_magnitude_comparator (16/4).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_magnitude_comparator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        signed_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        gt_out;
    logic        eq_out;
    logic        lt_out;
`ifdef CMP_MINMAX_EN
    logic [15:0] min_out;
    logic [15:0] max_out;
`endif

    int checks = 0;
    int errors = 0;

    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .gt_out      (gt_out),
        .eq_out      (eq_out),
        .lt_out      (lt_out)
`ifdef CMP_MINMAX_EN
        ,
        .min_out     (min_out),
        .max_out     (max_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one transaction and wait for out_valid; result and latency are checked.
    task automatic start_txn(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                             input logic sm, input logic [2:0] exp_res, input int exp_lat);
        int lat;
        lat = 0;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = ta;
        b = tb;
        signed_mode = sm;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        signed_mode = ~sm;
        a = ~ta;
        b = ~tb;
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, 32'({gt_out, eq_out, lt_out}), 32'(exp_res));
    endtask

    task automatic end_txn(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_ovalid_clr"}, 32'(out_valid), 32'd0);
        check({tag, "_res_clr"}, 32'({gt_out, eq_out, lt_out}), 32'd0);
        check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #12;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_res", 32'({gt_out, eq_out, lt_out}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start_txn("u_8000_7fff", 16'h8000, 16'h7FFF, 1'b0, 3'b100, 1);  end_txn("t1");
        start_txn("eq_1234",     16'h1234, 16'h1234, 1'b0, 3'b010, 4);  end_txn("t2");
        start_txn("u_1235_1234", 16'h1235, 16'h1234, 1'b0, 3'b100, 4);  end_txn("t3");
        start_txn("s_8000_0001", 16'h8000, 16'h0001, 1'b1, 3'b001, 1);  end_txn("t4");
        start_txn("u_8000_0001", 16'h8000, 16'h0001, 1'b0, 3'b100, 1);  end_txn("t5");
        start_txn("s_ffff_fffe", 16'hFFFF, 16'hFFFE, 1'b1, 3'b100, 4);  end_txn("t6");
        start_txn("eq_zero",     16'h0000, 16'h0000, 1'b0, 3'b010, 4);  end_txn("t7");
        start_txn("eq_ones_s",   16'hFFFF, 16'hFFFF, 1'b1, 3'b010, 4);  end_txn("t8");
        start_txn("u_00e0_00f0", 16'h00E0, 16'h00F0, 1'b0, 3'b001, 3);  end_txn("t9");
        start_txn("s_7fff_8000", 16'h7FFF, 16'h8000, 1'b1, 3'b100, 1);  end_txn("t10");

`ifdef CMP_MINMAX_EN
        start_txn("s_fffe_0003", 16'hFFFE, 16'h0003, 1'b1, 3'b001, 1);
        check("min_out", 32'(min_out), 32'h0000FFFE);
        check("max_out", 32'(max_out), 32'h00000003);
        end_txn("t11");
        start_txn("eq_mm", 16'h0055, 16'h0055, 1'b0, 3'b010, 4);
        check("eq_min", 32'(min_out), 32'h00000055);
        check("eq_max", 32'(max_out), 32'h00000055);
        end_txn("t12");
`endif

        // Backpressure: result held in DONE, in_valid pulses ignored
        out_ready = 1'b0;
        start_txn("bp", 16'h0003, 16'h0002, 1'b0, 3'b100, 4);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            a = 16'h0000;
            b = 16'hFFFF;
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_res", 32'({gt_out, eq_out, lt_out}), 32'b100);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        a = 16'h0001;
        b = 16'h0100;
        signed_mode = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_next_accept", 32'(in_ready), 32'd0);
        begin
            int lat;
            lat = 0;
            while (!out_valid && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("bp_next_lat", 32'(lat), 32'd2);
            check("bp_next_res", 32'({gt_out, eq_out, lt_out}), 32'b001);
        end
        end_txn("t_bp");

        // Reset in the middle of CMP aborts the transaction
        @(negedge clk);
        a = 16'h0001;
        b = 16'h0002;
        signed_mode = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_ovalid", 32'(out_valid), 32'd0);
        check("rst_res", 32'({gt_out, eq_out, lt_out}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("rst_no_result", 32'(out_valid), 32'd0);
        end
        check("rst_ready_after", 32'(in_ready), 32'd1);

        start_txn("post_rst", 16'h4000, 16'h4000, 1'b0, 3'b010, 4);
        end_txn("t_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
